// File: rtl/ehl_ahb_pkg.sv
// ---------------------------------------------------------------------------
// ehl_ahb_pkg
// Shared AHB-Lite encodings for the ehl AHB blocks.
//   htrans_e      : HTRANS transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST_SINGLE : burst encoding for single transfers
//   HSIZE_*       : byte/halfword/word transfer sizes
//   HRESP_*       : OKAY/ERROR response encodings
//   HPROT_DEFAULT : non-cacheable, non-bufferable, privileged, data access
//   is_err_resp() : any non-OKAY response (ERROR, RETRY, SPLIT) counts as error
// ---------------------------------------------------------------------------
package ehl_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // RETRY/SPLIT are not supported by AHB-Lite slaves; fold them into ERROR.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return (resp != HRESP_OKAY);
  endfunction

endpackage

// File: rtl/ehl_ahb_master_lite.sv
// ---------------------------------------------------------------------------
// ehl_ahb_master_lite
// Single-initiator AHB-Lite master. Turns a valid/ready command stream into
// AHB SINGLE transfers, one response pulse per command, with the address
// phase of command N+1 overlapping the data phase of command N.
//
// Handshake: a command transfers on a rising hclk edge where
// cmd_valid & cmd_ready are both 1; cmd_ready is combinational and may fall
// whenever hready falls. rsp_valid is a one-cycle pulse with no backpressure;
// rsp_rdata/rsp_err keep their last value between pulses.
//
// Ports
//   hclk, hresetn          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake
//   cmd_write/addr/size/wdata : command payload
//   rsp_valid/rsp_rdata/rsp_err : response (rdata is 0 for writes)
//   haddr/htrans/hwrite/hsize/hburst/hprot/hwdata : AHB master outputs
//   hready/hresp/hrdata    : AHB slave inputs
// ---------------------------------------------------------------------------
module ehl_ahb_master_lite
  import ehl_ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = HPROT_DEFAULT
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata
);

  // Address-phase register (AP)
  htrans_e     htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] wdata_q, wdata_d;
  // Data-phase register
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic [31:0] hwdata_q, hwdata_d;
  // Set when an ERROR cancelled the pending NONSEQ; it must be reissued
  logic        replay_q, replay_d;
  // Response register
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic resp_err;
  logic err_first;
  logic ap_nonseq;
  logic cmd_accept;

  assign resp_err   = is_err_resp(hresp);
  // First cycle of the two-cycle ERROR response
  assign err_first  = dp_valid_q & ~hready & resp_err;
  assign ap_nonseq  = (htrans_q == HTRANS_NONSEQ);
  assign cmd_ready  = hready & ~replay_q & ~err_first;
  assign cmd_accept = cmd_valid & cmd_ready;

  always_comb begin
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    wdata_d     = wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    hwdata_d    = hwdata_q;
    replay_d    = replay_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    if (hready) begin
      // Data phase completes
      if (dp_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = resp_err;
        rsp_rdata_d = dp_write_q ? 32'h0 : hrdata;
      end
      // Address phase moves to data phase
      dp_valid_d = ap_nonseq;
      if (ap_nonseq) begin
        dp_write_d = hwrite_q;
        hwdata_d   = wdata_q;
      end
      // Refill the address slot: replay has priority (cmd_ready is low then)
      if (replay_q) begin
        if (ap_nonseq) begin
          replay_d = 1'b0;
          htrans_d = HTRANS_IDLE;
        end else begin
          htrans_d = HTRANS_NONSEQ;
        end
      end else if (cmd_accept) begin
        htrans_d = HTRANS_NONSEQ;
        haddr_d  = cmd_addr;
        hwrite_d = cmd_write;
        hsize_d  = cmd_size;
        wdata_d  = cmd_wdata;
      end else begin
        htrans_d = HTRANS_IDLE;
      end
    end else if (err_first && ap_nonseq) begin
      // Cancel the pipelined transfer; AP contents are kept for the replay
      htrans_d = HTRANS_IDLE;
      replay_d = 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= 32'h0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'h0;
      wdata_q     <= 32'h0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      hwdata_q    <= 32'h0;
      replay_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      wdata_q     <= wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      hwdata_q    <= hwdata_d;
      replay_q    <= replay_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_VAL;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
